// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the integer register file and its pending-write scoreboard.
package reg_file_sb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REGS   = 32;

  localparam logic [DEF_ADDR_WIDTH-1:0] REG_X0 = '0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: x0 forcing, same-cycle writeback bypass and busy masking.
module reg_read_port
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs,
  input  logic [NUM_REGS-1:0]                   busy,
  input  logic                                  wb_valid,
  input  logic [ADDR_WIDTH-1:0]                 wb_rd,
  input  logic [DATA_WIDTH-1:0]                 wb_data,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  rd_busy
);

  logic wb_hit;

  always_comb begin
    wb_hit  = wb_valid && (wb_rd == addr);
    rd_data = '0;
    rd_busy = 1'b0;
    if (addr != ADDR_WIDTH'(REG_X0)) begin
      rd_data = wb_hit ? wb_data : regs[addr];
      // A writeback landing this cycle retires the producer the reader waits on.
      rd_busy = busy[addr] & ~wb_hit;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file x0..x31 with per-register pending-write scoreboard for issue stalls.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  logic [DATA_WIDTH-1:0]               reg_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]                 busy_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_view;
  logic [NUM_REGS-1:0]                 busy_view;

  // x0 has no storage; it appears as a constant zero entry in the read views.
  always_comb begin
    regs_view[0] = '0;
    busy_view[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_view[i] = reg_q[i];
      busy_view[i] = busy_q[i];
    end
  end

  assign issue_ready = (issue_rd == ADDR_WIDTH'(REG_X0))
                     || !busy_view[issue_rd]
                     || (wb_valid && (wb_rd == issue_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_valid && (wb_rd == ADDR_WIDTH'(i))) begin
          reg_q[i] <= wb_data;
        end
        // A new producer supersedes one retiring in the same cycle.
        if (issue_valid && issue_ready && (issue_rd == ADDR_WIDTH'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wb_valid && (wb_rd == ADDR_WIDTH'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rs1_port (
    .addr     (rs1_addr),
    .regs     (regs_view),
    .busy     (busy_view),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rd_data  (rs1_data),
    .rd_busy  (rs1_busy)
  );

  reg_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rs2_port (
    .addr     (rs2_addr),
    .regs     (regs_view),
    .busy     (busy_view),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rd_data  (rs2_data),
    .rd_busy  (rs2_busy)
  );

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Integer register file for the RISC-V core, with a per-register pending-write scoreboard. It holds x0..x31 and sits between the register address decoder and the execute/writeback stages. It takes rs1/rs2/rd indices, returns operand data with same-cycle writeback bypass, and flags operands whose producer has issued but not yet written back. The issue stage uses the busy flags to stall.

## Interface
Parameters:
- DATA_WIDTH, 32, register width (XLEN).
- ADDR_WIDTH, 5, register index width; equals `rs1_width/`rs2_width/`rd_width from parameters.vh.
- NUM_REGS, 32, number of architectural registers; index 0 is x0.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  ADDR_WIDTH  read port 1 index.
- rs2_addr  in  ADDR_WIDTH  read port 2 index.
- rs1_data  out  DATA_WIDTH  read port 1 data (combinational).
- rs2_data  out  DATA_WIDTH  read port 2 data (combinational).
- rs1_busy  out  1  rs1 has an outstanding producer.
- rs2_busy  out  1  rs2 has an outstanding producer.
- issue_valid  in  1  an instruction writing issue_rd is issuing this cycle.
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- issue_ready  out  1  issue may proceed without a WAW hazard on issue_rd.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  ADDR_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.

## Operation
- State: regs[1..31] (DATA_WIDTH each) and busy[1..31]. x0 has no storage.
- Read, per port: if addr==0, data=0 and busy=0. Else if wb_valid and wb_rd==addr, data=wb_data (bypass). Else data=regs[addr].
- Busy read: busy_out = busy[addr] & ~(wb_valid & wb_rd==addr). An issue in the same cycle does not affect busy_out; the issuing instruction is younger than the reader.
- Write: at the clock edge, if wb_valid and wb_rd!=0, regs[wb_rd] <= wb_data. wb_rd==0 is ignored entirely.
- Scoreboard update at the edge, for register r != 0:
  - Set if issue_valid & issue_ready & issue_rd==r.
  - Else clear if wb_valid & wb_rd==r.
  - Else hold.
  - Set has priority when issue and writeback target the same r in one cycle, because the new producer supersedes the old one.
- issue_ready = (issue_rd==0) | ~busy[issue_rd] | (wb_valid & wb_rd==issue_rd). It is independent of issue_valid.
- Issue with issue_valid=1 and issue_ready=0 has no state effect. The requester must hold.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- Only one outstanding producer per register. issue_ready enforces this.

## Timing
- Reads: zero-latency combinational from addresses and writeback inputs.
- Writes and busy updates: take effect at the next rising edge and are visible on reads in the following cycle. The bypass covers the write cycle itself.
- Reset (rst_n low, asynchronous): all regs clear to 0 and all busy clear to 0 immediately, independent of clk.
  - Outputs during reset: rsX_data=0 unless bypassed by wb, rsX_busy=0, issue_ready=1.
  - Reset asserted mid-operation discards all pending state. The first edge after deassertion takes normal updates.
- No multi-cycle operations and no internal FSM beyond the per-register busy bits.

## Structure
- Shared package/header (parameters.vh): DATA_WIDTH, ADDR_WIDTH and NUM_REGS defaults, reusing `rs1_width/`rs2_width/`rd_width. Add a REG_X0 constant (0).
- One sub-module, reg_read_port: addr, regs, busy, wb_* inputs to data and busy outputs. It is instantiated twice, for rs1 and rs2.
- Storage and scoreboard are flop arrays in the top module. There is no RAM macro, because of the asynchronous reset.

## Test plan
- Reset then read: assert rst_n=0 mid-run → rs1_addr=5 gives rs1_data=0, rs1_busy=0, issue_ready=1 immediately, without waiting for a clock edge.
- Write then read: wb x7=0xDEADBEEF, then rs1_addr=7 next cycle → 0xDEADBEEF. wb_rd=0 with 0x1234 → x0 still reads 0.
- Bypass: wb x3=0xA5A5A5A5 and rs2_addr=3 in the same cycle → rs2_data=0xA5A5A5A5, rs2_busy=0.
- Scoreboard: issue rd=9 → next cycle rs1_addr=9 gives rs1_busy=1, and issue_rd=9 gives issue_ready=0. Then wb x9 → busy clears in that cycle (combinationally) and stays 0 after the edge.
- Simultaneous issue and writeback to x4 with busy[4]=1 → issue_ready=1, x4 takes wb_data, and busy[4]=1 after the edge.
- Stalled issue: busy[12]=1, issue_valid=1, issue_rd=12, no wb → issue_ready=0 and busy[12] is unchanged. issue_rd=0 always gives issue_ready=1 and never sets busy.
